// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus.
//   SZ_*         : bus size codes (also the MEM-stage request size encoding)
//   state_e      : bus master FSM states
//   STDOUT_ADDR,
//   EXIT_ADDR    : memory-mapped device addresses; the master passes them
//                  through unmodified like any other address
//   norm_size    : folds the reserved code 2'b11 onto byte
//   is_aligned   : natural-alignment test for a given size
package mem_bus_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [31:0] STDOUT_ADDR = 32'hf000_0000;
  localparam logic [31:0] EXIT_ADDR   = 32'hff00_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_BYTE : size;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_WORD: return (addr_lo == 2'b00);
      SZ_HALF: return (addr_lo[0] == 1'b0);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension of the captured bus word.
//   size        : normalized bus size code (word / half / byte)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   bus_word    : right-aligned data as returned on the bus
//   ext_word    : extended result
module load_extend
  import mem_bus_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   size,
  input  logic         is_unsigned,
  input  logic [W-1:0] bus_word,
  output logic [W-1:0] ext_word
);

  logic fill_half;
  logic fill_byte;

  assign fill_half = ~is_unsigned & bus_word[15];
  assign fill_byte = ~is_unsigned & bus_word[7];

  always_comb begin
    ext_word = bus_word;
    case (size)
      SZ_WORD: ext_word = bus_word;
      SZ_HALF: ext_word = {{(W-16){fill_half}}, bus_word[15:0]};
      default: ext_word = {{(W-8){fill_byte}}, bus_word[7:0]};
    endcase
  end

endmodule

// File: rtl/dmem_bus_master.sv
// Processor-side initiator for the data-memory bus. Accepts one load/store
// at a time from the MEM stage, runs one bus cycle, and returns extended
// load data with a one-cycle done pulse.
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : MEM-stage access (valid, write, size, unsigned, addr, wdata)
//   stall           : combinational pipeline hold (req_valid & ~done)
//   done, err       : one-cycle completion / error pulses
//   rdata           : extended load data, valid with done
//   DAD/MREQ/WRITE/SIZE : registered bus address and control
//   ACKD_n          : responder acknowledge, active-low, honoured only in BUSY
//   DDT             : bidirectional bus data, driven only during a store
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no access in flight, waiting for req_valid
// BUSY    | bus cycle running (MREQ=1), waiting for ACKD_n or timeout
// DONE    | one-cycle retire: done pulses, bus released
module dmem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 stall,
  output logic                 done,
  output logic                 err,
  output logic [BIT_WIDTH-1:0] rdata,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  // Abort fires on the edge that ends the TIMEOUT-th BUSY cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e               state;
  state_e               state_d;
  logic [7:0]           tmo_cnt;
  logic                 unsigned_q;
  logic                 ddt_oe;
  logic [BIT_WIDTH-1:0] ddt_out;
  logic [BIT_WIDTH-1:0] load_ext;

  logic [1:0]           size_n;
  logic                 aligned;
  logic                 ack;
  logic                 tmo_hit;
  logic [BIT_WIDTH-1:0] wdata_fmt;

  logic                 accept;
  logic                 misalign;
  logic                 capture;
  logic                 abort;
  logic                 mreq_d;
  logic                 done_d;
  logic                 err_d;
  logic                 ddt_oe_d;

  assign size_n  = norm_size(req_size);
  assign aligned = is_aligned(size_n, req_addr[1:0]);
  assign ack     = ~ACKD_n;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    wdata_fmt = req_wdata;
    case (size_n)
      SZ_WORD: wdata_fmt = req_wdata;
      SZ_HALF: wdata_fmt = BIT_WIDTH'(req_wdata[15:0]);
      default: wdata_fmt = BIT_WIDTH'(req_wdata[7:0]);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic; ACK is checked before the timeout so it wins a tie.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (req_valid) state_d = aligned ? ST_BUSY : ST_DONE;
      ST_BUSY: if (ack || tmo_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered bus/status outputs.
  always_comb begin
    accept   = (state == ST_IDLE) && req_valid && aligned;
    misalign = (state == ST_IDLE) && req_valid && !aligned;
    capture  = (state == ST_BUSY) && ack;
    abort    = (state == ST_BUSY) && !ack && tmo_hit;
    mreq_d   = (state_d == ST_BUSY);
    done_d   = (state_d == ST_DONE);
    err_d    = misalign || abort;
    ddt_oe_d = mreq_d && (accept ? req_write : WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MREQ       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ddt_oe     <= 1'b0;
      DAD        <= '0;
      SIZE       <= SZ_WORD;
      WRITE      <= 1'b0;
      unsigned_q <= 1'b0;
      ddt_out    <= '0;
      rdata      <= '0;
      tmo_cnt    <= '0;
    end else begin
      MREQ   <= mreq_d;
      done   <= done_d;
      err    <= err_d;
      ddt_oe <= ddt_oe_d;

      if (accept) begin
        DAD        <= req_addr;
        SIZE       <= size_n;
        WRITE      <= req_write;
        unsigned_q <= req_unsigned;
        ddt_out    <= wdata_fmt;
      end

      if (state_d != ST_BUSY)   tmo_cnt <= '0;
      else if (state == ST_BUSY) tmo_cnt <= tmo_cnt + 8'd1;

      if (capture)                rdata <= load_ext;
      else if (abort || misalign) rdata <= '0;
    end
  end

  assign DDT = ddt_oe ? ddt_out : 'z;

  load_extend #(.W(BIT_WIDTH)) u_load_extend (
    .size        (SIZE),
    .is_unsigned (unsigned_q),
    .bus_word    (DDT),
    .ext_word    (load_ext)
  );

  assign stall = req_valid & ~done;

endmodule

// File: tb/tb_dmem_bus_master.sv
module tb_dmem_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;
  wire  [31:0] DDT;

  // responder side
  logic        ddt_en;
  logic [31:0] ddt_drv;
  logic [31:0] resp_data;
  int          ack_delay;
  int          busy_n;
  int          mreq_cycles;
  int          done_pulses;
  int          err_pulses;
  logic [31:0] obs_dad;
  logic [1:0]  obs_size;
  logic        obs_write;
  logic [31:0] obs_ddt;

  int n_checks = 0;
  int n_err    = 0;

  assign DDT = ddt_en ? ddt_drv : 'z;

  always #5 clk = ~clk;

  dmem_bus_master #(.BIT_WIDTH(32), .TIMEOUT(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .DAD          (DAD),
    .MREQ         (MREQ),
    .WRITE        (WRITE),
    .SIZE         (SIZE),
    .ACKD_n       (ACKD_n),
    .DDT          (DDT)
  );

  // Responder: ACKs after ack_delay BUSY cycles (0 = never), drives load data.
  always @(negedge clk) begin
    if (done) done_pulses = done_pulses + 1;
    if (err)  err_pulses  = err_pulses + 1;
    if (MREQ) begin
      busy_n      = busy_n + 1;
      mreq_cycles = mreq_cycles + 1;
      obs_dad     = DAD;
      obs_size    = SIZE;
      obs_write   = WRITE;
      if (WRITE) begin
        ddt_en  = 1'b0;
        obs_ddt = DDT;
      end else begin
        ddt_en  = 1'b1;
        ddt_drv = resp_data;
      end
      if (ack_delay != 0 && busy_n >= ack_delay) ACKD_n = 1'b0;
    end else begin
      busy_n = 0;
      ACKD_n = 1'b1;
      ddt_en = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access from IDLE: runs until done (bounded), then one more cycle back to IDLE.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] resp,
                        input int delay, input int exp_cycles, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_mreq, input logic [1:0] exp_size,
                        input logic [31:0] exp_ddt);
    int   cycles;
    logic stall_ok;
    logic err_seen;
    logic [31:0] rd_seen;
    mreq_cycles = 0;
    done_pulses = 0;
    err_pulses  = 0;
    resp_data   = resp;
    ack_delay   = delay;
    req_write   = w;
    req_size    = sz;
    req_unsigned = u;
    req_addr    = a;
    req_wdata   = wd;
    req_valid   = 1'b1;
    #1;
    stall_ok = stall;
    cycles   = 0;
    while (cycles <= exp_cycles + 20) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
      if (!stall) stall_ok = 1'b0;
    end
    err_seen = err;
    rd_seen  = rdata;
    if (stall) stall_ok = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
    chk({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
    chk({tag, "_err"}, {31'd0, err_seen}, {31'd0, exp_err});
    chk({tag, "_mreq_cycles"}, 32'(mreq_cycles), 32'(exp_mreq));
    chk({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
    chk({tag, "_err_pulses"}, 32'(err_pulses), {31'd0, exp_err});
    chk({tag, "_mreq_after"}, {31'd0, MREQ}, 32'd0);
    if (!w) chk({tag, "_rdata"}, rd_seen, exp_rdata);
    if (exp_mreq > 0) begin
      chk({tag, "_dad"}, obs_dad, a);
      chk({tag, "_size"}, {30'd0, obs_size}, {30'd0, exp_size});
      chk({tag, "_write"}, {31'd0, obs_write}, {31'd0, w});
      if (w) chk({tag, "_ddt"}, obs_ddt, exp_ddt);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    ACKD_n = 1'b1; ddt_en = 1'b0; ddt_drv = '0; resp_data = '0; ack_delay = 1;
    busy_n = 0; mreq_cycles = 0; done_pulses = 0; err_pulses = 0;
    obs_dad = '0; obs_size = '0; obs_write = 1'b0; obs_ddt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mreq",  {31'd0, MREQ}, 32'd0);
    chk("rst_write", {31'd0, WRITE}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_size",  {30'd0, SIZE}, 32'd0);
    chk("rst_dad",   DAD, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //      tag      w     sz     u     addr          wdata         resp          dly cyc rdata         err   mreq sz     ddt
    access("lw",     1'b0, 2'b00, 1'b0, 32'h0800_0004, 32'h0,       32'hDEAD_BEEF, 1,  2, 32'hDEAD_BEEF, 1'b0, 1, 2'b00, 32'h0);
    access("lb",     1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0,       32'h0000_0080, 1,  2, 32'hFFFF_FF80, 1'b0, 1, 2'b10, 32'h0);
    access("lbu",    1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0,       32'h0000_0080, 1,  2, 32'h0000_0080, 1'b0, 1, 2'b10, 32'h0);
    access("lh",     1'b0, 2'b01, 1'b0, 32'h0800_0002, 32'h0,       32'h0000_8001, 1,  2, 32'hFFFF_8001, 1'b0, 1, 2'b01, 32'h0);
    access("lhu",    1'b0, 2'b01, 1'b1, 32'h0800_0006, 32'h0,       32'hABCD_8001, 2,  3, 32'h0000_8001, 1'b0, 2, 2'b01, 32'h0);
    access("lb11",   1'b0, 2'b11, 1'b0, 32'h0800_0001, 32'h0,       32'h1234_56FF, 1,  2, 32'hFFFF_FFFF, 1'b0, 1, 2'b10, 32'h0);
    access("sb",     1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h1234_5641, 32'h0,       3,  4, 32'h0,         1'b0, 3, 2'b10, 32'h0000_0041);
    access("sh",     1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'hAAAA_1234, 32'h0,       1,  2, 32'h0,         1'b0, 1, 2'b01, 32'h0000_1234);
    access("sw",     1'b1, 2'b00, 1'b0, 32'hFF00_0000, 32'hCAFE_F00D, 32'h0,       1,  2, 32'h0,         1'b0, 1, 2'b00, 32'hCAFE_F00D);
    access("lw_pre", 1'b0, 2'b00, 1'b0, 32'h0800_0008, 32'h0,       32'h5555_AAAA, 1,  2, 32'h5555_AAAA, 1'b0, 1, 2'b00, 32'h0);
    access("mis_w",  1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0,       32'h1111_1111, 1,  1, 32'h0,         1'b1, 0, 2'b00, 32'h0);
    access("mis_h",  1'b1, 2'b01, 1'b0, 32'h0800_0001, 32'h0,       32'h0,         1,  1, 32'h0,         1'b1, 0, 2'b00, 32'h0);
    access("ack255", 1'b0, 2'b00, 1'b0, 32'h0800_000C, 32'h0,       32'h7777_0001, 255, 256, 32'h7777_0001, 1'b0, 255, 2'b00, 32'h0);
    access("tmo",    1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0,       32'h9999_9999, 0,  256, 32'h0,       1'b1, 255, 2'b00, 32'h0);

    // Reset in the middle of a store that is never acknowledged.
    mreq_cycles = 0; done_pulses = 0; err_pulses = 0;
    ack_delay = 0; resp_data = '0;
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0800_0020; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstb_mreq_busy", {31'd0, MREQ}, 32'd1);
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstb_mreq_after", {31'd0, MREQ}, 32'd0);
    chk("rstb_done_after", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstb_no_done", 32'(done_pulses), 32'd0);
    access("post_rst", 1'b0, 2'b00, 1'b0, 32'h0800_0024, 32'h0, 32'h1357_9BDF, 1, 2, 32'h1357_9BDF, 1'b0, 1, 2'b00, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_bus_master.md
# dmem_bus_master

Processor-side initiator for the data-memory bus. It takes one load or store at a time from the MEM stage and drives DAD/MREQ/WRITE/SIZE/DDT, then waits for the responder's active-low ACKD_n. It returns aligned, sign- or zero-extended load data and holds the pipeline stalled until the access completes. It sits between the MEM stage and the `top` bus pins, opposite the memory model/responder.

## Interface
- `BIT_WIDTH`, 32, bus and data width
- `TIMEOUT`, 255, maximum BUSY cycles before abort (8-bit counter)
- `clk` input 1: clock, rising edge
- `rst` input 1: reset, synchronous, active-high
- `req_valid` input 1: MEM stage has a memory access
- `req_write` input 1: 1 = store, 0 = load
- `req_size` input 2: 00 word, 01 halfword, 10 byte (11 treated as byte)
- `req_unsigned` input 1: zero-extend load (LBU/LHU)
- `req_addr` input 32: byte address
- `req_wdata` input 32: store data, right-aligned
- `stall` output 1: hold pipeline
- `done` output 1: one-cycle completion pulse
- `err` output 1: one-cycle pulse on misaligned access or timeout
- `rdata` output 32: extended load data, valid when `done`
- `DAD` output 32: bus address
- `MREQ` output 1: bus request
- `WRITE` output 1: bus direction
- `SIZE` output 2: bus size code, same encoding as `req_size`
- `ACKD_n` input 1: responder acknowledge, active-low
- `DDT` inout 32: bus data

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - When `req_valid` is high and the access is aligned (word: addr[1:0]=00; half: addr[0]=0), latch addr/size/write/wdata/unsigned and go to BUSY.
  - When the access is misaligned, pulse `err` next cycle, go to DONE, and drive no bus cycle.
- **BUSY**
  - `MREQ`=1; `DAD`, `SIZE`, `WRITE` come from latched values and stay stable.
  - On a store, DDT is driven with: word = wdata; half = {16'b0, wdata[15:0]}; byte = {24'b0, wdata[7:0]}.
  - On a load, DDT is high-Z.
  - When ACKD_n is sampled 0 at a rising edge, capture DDT into `rdata` and go to DONE.
  - Otherwise the timeout counter increments. At `TIMEOUT` the access aborts: go to DONE with `err`=1 and `rdata`=0.
- **DONE**
  - `done`=1 for exactly one cycle, `MREQ`=0, DDT released; then go to IDLE.
  - A `req_valid` seen in DONE is the retiring request and is ignored.
- Load extension:
  - half = sign/zero-extend DDT[15:0];
  - byte = sign/zero-extend DDT[7:0];
  - word = DDT unchanged.
  - Data is right-aligned on DDT; byte-lane placement inside memory belongs to the responder.
- `stall` = `req_valid` & ~`done` (combinational).

## Timing
- Reset values: state IDLE; `MREQ`, `WRITE`, `done`, `err` = 0; `SIZE`=00; `DAD`=0; `rdata`=0; DDT high-Z; counter 0.
- Cycle sequence with a 1-cycle responder:
  - c0: IDLE sees the request.
  - c1: BUSY with MREQ=1; ACK sampled low at the end of c1.
  - c2: DONE with rdata valid.
  - c3: IDLE.
- Minimum occupancy is 3 cycles; each extra ACK wait cycle adds one.
- ACKD_n is ignored outside BUSY.
- ACK sampled on the same edge the counter reaches `TIMEOUT`: ACK wins, no `err`.
- `rst` asserted mid-BUSY: next cycle MREQ=0, DDT released, `done` is not pulsed, and the request is lost.
- Bus outputs are all registered; only `stall` is combinational.

## Structure
- Shared package `mem_bus_pkg`:
  - SIZE constants `SZ_WORD`=2'b00, `SZ_HALF`=2'b01, `SZ_BYTE`=2'b10;
  - the FSM state enum;
  - `STDOUT_ADDR`=32'hf000_0000 and `EXIT_ADDR`=32'hff00_0000 (addresses pass through unmodified).
- One sub-module: `load_extend`, a combinational size/unsigned extension of the captured bus word.

## Test plan
- **Word load:** req addr 0x0800_0004, responder returns 0xDEADBEEF with 1-cycle ACK -> MREQ=1 for 1 cycle, DAD=0x0800_0004, SIZE=00, `done` in c2, rdata=0xDEADBEEF, stall high in c0–c1.
- **Signed and unsigned byte load:**
  - DDT=0x0000_0080, LB -> rdata=0xFFFF_FF80.
  - Same with LBU -> 0x0000_0080.
  - Half with DDT[15:0]=0x8001, LH -> 0xFFFF_8001.
- **Store byte to 0xF000_0000:** wdata=0x1234_5641 -> DDT=0x0000_0041, WRITE=1, SIZE=10; responder ACKs after 3 cycles -> MREQ held 3 cycles, `done` one cycle later.
- **Misaligned:** word load at 0x0800_0002 -> no MREQ, `err` and `done` pulse once, stall released.
- **Timeout:** ACKD_n held high -> `err`/`done` after exactly 255 BUSY cycles, rdata=0.
- **Reset mid-BUSY:** `rst` asserted -> MREQ=0 and DDT high-Z next cycle, no `done`; the next request works normally.
